// File: rtl/mc_main_control_pkg.sv
// Shared encodings for the multi-cycle RV32 main control FSM: states, opcodes,
// ALU operation selects and the bundled datapath strobe record.
package mc_main_control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8
  } state_t;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == LW) || (op == SW) || (op == RTYPE) || (op == BEQ);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore strobe decode: maps the current state (plus mem_ready for the fetch
// handshake) onto the datapath control record.
module mc_ctrl_decode
  import mc_main_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        // IR and PC only load on the cycle the instruction word actually arrives
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RWB: begin
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM for the RV32 datapath (lw, sw, R-type, beq).
// Holds the state register and next-state logic; strobes come from mc_ctrl_decode.
module mc_main_control
  import mc_main_control_pkg::*;
#(
  parameter int OPW = 7,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           pc_source,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           illegal,
  output logic [STW-1:0] state
);

  state_t state_q;
  state_t state_nx;
  logic   illegal_raw;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx    = FETCH;
    illegal_raw = 1'b0;
    unique case (state_q)
      FETCH:    state_nx = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if ((opcode == LW) || (opcode == SW)) state_nx = MEMADDR;
        else if (opcode == RTYPE)             state_nx = EXEC;
        else if (opcode == BEQ)               state_nx = BRANCH;
        else begin
          state_nx    = FETCH;
          illegal_raw = !op_supported(opcode);
        end
      end
      // IR is stable after DECODE, so re-sampling opcode here is safe
      MEMADDR: begin
        if (opcode == LW)      state_nx = MEMREAD;
        else if (opcode == SW) state_nx = MEMWRITE;
        else                   state_nx = FETCH;
      end
      MEMREAD:  state_nx = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_nx = FETCH;
      MEMWRITE: state_nx = mem_ready ? FETCH : MEMWRITE;
      EXEC:     state_nx = RWB;
      RWB:      state_nx = FETCH;
      BRANCH:   state_nx = FETCH;
      default:  state_nx = FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  // Reset held low must silence every strobe, even though FETCH normally reads memory
  assign ctrl_g = rst_n ? ctrl_raw : '0;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign pc_source     = ctrl_g.pc_source;
  assign i_or_d        = ctrl_g.i_or_d;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign alu_op        = ctrl_g.alu_op;
  assign illegal       = rst_n & illegal_raw;
  assign state         = rst_n ? STW'(state_q) : '0;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: each instruction is expanded into its expected
// per-cycle trace and every cycle's outputs are compared against it.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  logic [31:0] seq;
  int          ncyc, n_rw, n_mw, n_ill;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal       (illegal),
    .state         (state)
  );

  wire [18:0] dut_vec = {state, pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                         mem_write, ir_write, mem_to_reg, reg_write, alu_src_a,
                         alu_src_b, alu_op, illegal};

  // Spec table: which strobes each phase raises
  function automatic logic [18:0] exp_for(input int st, input bit mr, input bit ill);
    logic [3:0] s;
    bit pw, pwc, ps, iod, mrd, mwr, irw, m2r, rw, sa, il;
    logic [1:0] sb, ao;
    {pw, pwc, ps, iod, mrd, mwr, irw, m2r, rw, sa, il} = '0;
    sb = 2'b00; ao = 2'b00;
    s = 4'(st);
    case (st)
      0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      1: begin sb = 2'b10; il = ill; end
      2: begin sa = 1; sb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iod = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; end
      8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 1; end
      default: ;
    endcase
    return {s, pw, pwc, ps, iod, mrd, mwr, irw, m2r, rw, sa, sb, ao, il};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; compares on the falling edge, returns at next posedge+1
  task automatic cycle(input bit mr, input logic [18:0] exp);
    mem_ready = mr;
    @(negedge clk);
    check($sformatf("cycle st=%0d", exp[18:15]), {13'd0, dut_vec}, {13'd0, exp});
    seq = {seq[27:0], state};
    ncyc++;
    if (reg_write) n_rw++;
    if (mem_write) n_mw++;
    if (illegal)   n_ill++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait);
    bit legal;
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ);
    seq = 0; ncyc = 0; n_rw = 0; n_mw = 0; n_ill = 0;
    opcode = op;
    for (int i = 0; i < fwait; i++) cycle(1'b0, exp_for(0, 1'b0, 1'b0));
    cycle(1'b1, exp_for(0, 1'b1, 1'b0));
    cycle(1'($urandom), exp_for(1, 1'b0, !legal));
    if (op == OP_LW || op == OP_SW) begin
      cycle(1'($urandom), exp_for(2, 1'b0, 1'b0));
      for (int i = 0; i < mwait; i++) cycle(1'b0, exp_for(op == OP_LW ? 3 : 5, 1'b0, 1'b0));
      cycle(1'b1, exp_for(op == OP_LW ? 3 : 5, 1'b1, 1'b0));
      if (op == OP_LW) cycle(1'($urandom), exp_for(4, 1'b0, 1'b0));
    end else if (op == OP_R) begin
      cycle(1'($urandom), exp_for(6, 1'b0, 1'b0));
      cycle(1'($urandom), exp_for(7, 1'b0, 1'b0));
    end else if (op == OP_BEQ) begin
      cycle(1'($urandom), exp_for(8, 1'b0, 1'b0));
    end
  endtask

  initial begin
    logic [6:0] op;
    int k;
    #2;
    check("reset_outputs_zero", {13'd0, dut_vec}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(OP_R, 0, 0);
    check("rtype_seq", seq, 32'h0167);
    check("rtype_cycles", ncyc, 4);
    check("rtype_regwrite", n_rw, 1);

    run_instr(OP_LW, 0, 2);
    check("lw_seq", seq, 32'h0123334);
    check("lw_cycles", ncyc, 7);

    run_instr(OP_SW, 0, 0);
    check("sw_seq", seq, 32'h0125);
    check("sw_memwrite", n_mw, 1);
    check("sw_regwrite", n_rw, 0);

    run_instr(OP_BEQ, 0, 0);
    check("beq_seq", seq, 32'h018);
    check("beq_cycles", ncyc, 3);

    run_instr(7'b0010011, 0, 0);
    check("illegal_seq", seq, 32'h01);
    check("illegal_pulse", n_ill, 1);
    check("illegal_nowrite", n_rw + n_mw, 0);
    cycle(1'b0, exp_for(0, 1'b0, 1'b0));

    // Reset asserted in the middle of MEMWB
    opcode = OP_LW;
    cycle(1'b1, exp_for(0, 1'b1, 1'b0));
    cycle(1'b1, exp_for(1, 1'b0, 1'b0));
    cycle(1'b1, exp_for(2, 1'b0, 1'b0));
    cycle(1'b1, exp_for(3, 1'b1, 1'b0));
    #2;
    check("memwb_reached", {28'd0, state}, 32'd4);
    rst_n = 1'b0;
    #1;
    check("mid_reset_zero", {13'd0, dut_vec}, 32'd0);
    @(posedge clk);
    #1;
    check("held_reset_zero", {13'd0, dut_vec}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_memread", {31'd0, mem_read}, 32'd1);
    check("post_reset_state", {28'd0, state}, 32'd0);
    cycle(1'b1, exp_for(0, 1'b1, 1'b0));
    cycle(1'b1, exp_for(1, 1'b0, 1'b0));
    cycle(1'b1, exp_for(2, 1'b0, 1'b0));
    cycle(1'b1, exp_for(3, 1'b1, 1'b0));
    cycle(1'b0, exp_for(4, 1'b0, 1'b0));

    // Randomized instruction mix with random memory stalls
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        default: begin
          op = 7'($urandom);
          if (op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ) op = 7'b0010011;
        end
      endcase
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the RV32 datapath.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type and beq.
- Drives every datapath strobe, including the 2-bit alu_op consumed by the ALU control unit:
  - 00 = add (address and PC arithmetic)
  - 01 = subtract (branch compare)
  - 10 = decode from funct
- Sits beside the ALU control unit. It takes opcode from the instruction register and a ready signal from memory.

Parameters:
- OPW, 7, opcode field width.
- STW, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by ALU zero, combined in the datapath.
- pc_source  out  1  0 = ALU result, 1 = ALUOut register.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  to the ALU control unit.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state, for debug.

Behaviour:
- Reset:
  - Asynchronous, active-low (rst_n).
  - State goes to FETCH.
  - While rst_n = 0, all outputs are forced to 0, including state.
  - First FETCH cycle is the first rising edge after rst_n deasserts.
- Moore outputs are decoded from the state register. ir_write and pc_write are additionally ANDed with mem_ready.
- Unlisted outputs are 0 in every state.
- Opcodes:
  - LW = 0000011
  - SW = 0100011
  - RTYPE = 0110011
  - BEQ = 1100011
- States, with encoding, outputs and transitions:
  - FETCH = 0:
    - Outputs: mem_read = 1, alu_src_b = 01, alu_op = 00; ir_write = pc_write = mem_ready.
    - Next: mem_ready ? DECODE : FETCH.
  - DECODE = 1:
    - Outputs: alu_src_b = 10, alu_op = 00 (branch target precomputed).
    - Next on LW or SW: MEMADDR.
    - Next on RTYPE: EXEC.
    - Next on BEQ: BRANCH.
    - Any other opcode: illegal = 1 this cycle, next FETCH.
  - MEMADDR = 2:
    - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
    - Next on LW: MEMREAD. Next on SW: MEMWRITE.
    - opcode is re-sampled in MEMADDR. The instruction register is stable, so it still matches DECODE.
  - MEMREAD = 3:
    - Outputs: mem_read = 1, i_or_d = 1.
    - Next: mem_ready ? MEMWB : MEMREAD.
  - MEMWB = 4:
    - Outputs: reg_write = 1, mem_to_reg = 1.
    - Next: FETCH.
  - MEMWRITE = 5:
    - Outputs: mem_write = 1, i_or_d = 1.
    - Next: mem_ready ? FETCH : MEMWRITE.
  - EXEC = 6:
    - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
    - Next: RWB.
  - RWB = 7:
    - Outputs: reg_write = 1, mem_to_reg = 0.
    - Next: FETCH.
  - BRANCH = 8:
    - Outputs: alu_src_a = 1, alu_op = 01, pc_write_cond = 1, pc_source = 1.
    - Next: FETCH.
- Unused encodings 9–15 go to FETCH on the next edge with all outputs 0.
- Cycles per instruction with mem_ready held 1:
  - beq: 3
  - R-type: 4
  - sw: 4
  - lw: 5
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. Request strobes stay asserted and stable while waiting.
- mem_ready is ignored in non-memory states.
- Reset mid-instruction: outputs drop to 0 immediately and the instruction is abandoned. No partial writeback occurs after rst_n falls.
- alu_op never takes the value 11.

Decomposition:
- Shared package holds:
  - state encodings (FETCH..BRANCH)
  - opcode constants (LW, SW, RTYPE, BEQ)
  - alu_op encodings (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10)
  - alu_src_b encodings
- One sub-module, mc_ctrl_decode: purely combinational, maps state and mem_ready to output strobes.
- The top level keeps the state register, next-state logic and reset gating.

Test Plan:
- Reset, then release with opcode = 0110011 and mem_ready = 1:
  - States FETCH → DECODE → EXEC → RWB → FETCH.
  - alu_op = 10 in EXEC.
  - reg_write = 1 only in RWB.
- lw with mem_ready = 0 for 2 cycles in MEMREAD:
  - MEMREAD lasts 3 cycles with mem_read = 1 and i_or_d = 1 throughout.
  - MEMWB then has reg_write = 1 and mem_to_reg = 1. Total 7 cycles.
- sw (0100011), mem_ready = 1:
  - Sequence 0, 1, 2, 5, 0.
  - mem_write = 1 for exactly one cycle.
  - reg_write is never asserted.
- beq (1100011):
  - BRANCH has alu_op = 01, pc_write_cond = 1, pc_source = 1.
  - Back in FETCH after 3 cycles.
- Opcode 0010011 in DECODE:
  - illegal = 1 for one cycle, next state FETCH.
  - No reg_write or mem_write occurs.
- rst_n pulled low during MEMWB:
  - All outputs are 0 in the same cycle and state = 0.
  - After release, FETCH with mem_read = 1.
